seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_bit_cnt.sv | 27 ++
 rtl/seq_gen.sv | 152 +++++++++++++++
 tb/tb_seq_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and default sizing for the serial pattern generator
// and its companion detector.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/seq_bit_cnt.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module seq_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// Serialises a pattern MSB-first, optionally repeating it, with abort support.
// state | meaning
// IDLE  | waiting for a load, load_ready high
// SHIFT | emitting pattern bits, out_valid high
// DONE  | one-cycle done pulse before returning to IDLE
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [CNT_W-1:0]           rpt,
  input  logic                       abort,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(WIDTH+1);
  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

  seq_state_e     state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] pal_q;
  logic [LW-1:0]    len_q;
  logic             out_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] pal_c;
  logic             load_fire;
  logic             step;
  logic             bit_zero;
  logic             rpt_zero;
  logic             bit_load;
  logic [LW-1:0]    bit_val;
  logic             bit_dec;
  logic             rpt_dec;

  // Left-align the pattern so bit len-1 sits at the MSB; the rest shift out.
  assign len_c     = (len > LEN_MAX) ? LEN_MAX : len;
  assign pal_c     = pattern << (LEN_MAX - len_c);
  assign load_fire = (state_q == ST_IDLE) && load_valid;
  assign step      = (state_q == ST_SHIFT) && !abort;

  assign bit_load = (load_fire && (len_c != '0)) || (step && bit_zero && !rpt_zero);
  assign bit_val  = load_fire ? (len_c - 1'b1) : (len_q - 1'b1);
  assign bit_dec  = step && !bit_zero;
  assign rpt_dec  = step && bit_zero && !rpt_zero;

  seq_bit_cnt #(.W(LW)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (bit_load),
    .val_i  (bit_val),
    .dec_i  (bit_dec),
    .zero_o (bit_zero)
  );

  seq_bit_cnt #(.W(CNT_W)) u_rpt_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_fire),
    .val_i  (rpt),
    .dec_i  (rpt_dec),
    .zero_o (rpt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      pal_q       <= '0;
      len_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            pal_q   <= pal_c;
            len_q   <= len_c;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (len_c == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_SHIFT;
              out_q       <= pal_c[WIDTH-1];
              out_valid_q <= 1'b1;
              sh_q        <= pal_c << 1;
            end
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
          end else if (bit_zero && rpt_zero) begin
            state_q     <= ST_DONE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (bit_zero) begin
            out_q <= pal_q[WIDTH-1];
            sh_q  <= pal_q << 1;
          end else begin
            out_q <= sh_q[WIDTH-1];
            sh_q  <= sh_q << 1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen with hand-computed bit streams.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rpt;
  logic       abort;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_gen #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .len        (len),
    .rpt        (rpt),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1);
  end

  // Present a load for one edge; returns at the sample point of cycle 1.
  task automatic drive_load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    pattern    = p;
    len        = l;
    rpt        = r;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out, out_valid, busy, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset: outputs got %b need 00001", {out, out_valid, busy, done, load_ready});
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    e = 4'b1101;
    drive_load(8'b0000_1101, 4'd4, 4'd0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({out_valid, out, done, load_ready} !== {1'b1, e[3-c], 2'b00}) begin
        errors++;
        $display("FAIL single bit%0d: got v/o/d/r=%b need %b", c, {out_valid, out, done, load_ready}, {1'b1, e[3-c], 2'b00});
      end
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid, out, busy, load_ready} !== 5'b10010) begin
      errors++;
      $display("FAIL single done: got d/v/o/b/r=%b need 10010", {done, out_valid, out, busy, load_ready});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single idle: got d/b/r=%b need 001", {done, busy, load_ready});
    end
  endtask

  task automatic test_repeat();
    logic [3:0] e;
    e = 4'b1101;
    drive_load(8'b0000_1101, 4'd4, 4'd2);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({out_valid, out, done} !== {1'b1, e[3-(c%4)], 1'b0}) begin
        errors++;
        $display("FAIL repeat bit%0d: got v/o/d=%b need %b", c, {out_valid, out, done}, {1'b1, e[3-(c%4)], 1'b0});
      end
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL repeat done: got d/v=%b need 10", {done, out_valid});
    end
    @(negedge clk);
    checks++;
    if ({done, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL repeat idle: got d/r=%b need 01", {done, load_ready});
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    e = 8'hA5;
    drive_load(8'hA5, 4'd8, 4'd0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_valid, out} !== {1'b1, e[7-c]}) begin
        errors++;
        $display("FAIL abort bit%0d: got v/o=%b need %b", c, {out_valid, out}, {1'b1, e[7-c]});
      end
      if (c == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if ({out_valid, out, done, busy, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL abort stop: got v/o/d/b/r=%b need 00001", {out_valid, out, done, busy, load_ready});
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({done, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL abort quiet%0d: got d/v=%b need 00", c, {done, out_valid});
      end
    end
  endtask

  task automatic test_ignored_load();
    logic [3:0] e;
    e = 4'b1101;
    drive_load(8'b0000_1101, 4'd4, 4'd0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({out_valid, out} !== {1'b1, e[3-c]}) begin
        errors++;
        $display("FAIL ignored bit%0d: got v/o=%b need %b", c, {out_valid, out}, {1'b1, e[3-c]});
      end
      if (c == 1) begin
        pattern    = 8'hFF;
        len        = 4'd8;
        rpt        = 4'd3;
        load_valid = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ignored done: got d/v=%b need 10", {done, out_valid});
    end
    load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL ignored idle: got r/v/b=%b need 100", {load_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    e = 3'b011;
    drive_load(8'hF0, 4'd8, 4'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out, out_valid, busy, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_mid async: got %b need 00001", {out, out_valid, busy, done, load_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    drive_load(8'b0000_0011, 4'd3, 4'd0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_valid, out} !== {1'b1, e[2-c]}) begin
        errors++;
        $display("FAIL reset_mid bit%0d: got v/o=%b need %b", c, {out_valid, out}, {1'b1, e[2-c]});
      end
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid done: got d/v=%b need 10", {done, out_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_len0();
    drive_load(8'hFF, 4'd0, 4'd5);
    abort = 1'b1;
    checks++;
    if ({done, out_valid, busy, load_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL len0 done: got d/v/b/r=%b need 1010", {done, out_valid, busy, load_ready});
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({done, out_valid, busy, load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL len0 idle: got d/v/b/r=%b need 0001", {done, out_valid, busy, load_ready});
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] e;
    e = 8'b1001_0110;
    drive_load(8'b1001_0110, 4'd15, 4'd0);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({out_valid, out} !== {1'b1, e[7-c]}) begin
        errors++;
        $display("FAIL clamp bit%0d: got v/o=%b need %b", c, {out_valid, out}, {1'b1, e[7-c]});
      end
      @(negedge clk);
    end
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL clamp done: got d/v=%b need 10", {done, out_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_abort_with_load();
    abort = 1'b1;
    drive_load(8'b0000_0010, 4'd2, 4'd0);
    abort = 1'b0;
    checks++;
    if ({out_valid, out} !== 2'b11) begin
      errors++;
      $display("FAIL abort_load bit0: got v/o=%b need 11", {out_valid, out});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out} !== 2'b10) begin
      errors++;
      $display("FAIL abort_load bit1: got v/o=%b need 10", {out_valid, out});
    end
    @(negedge clk);
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_load done: got d/v=%b need 10", {done, out_valid});
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    pattern    = '0;
    len        = '0;
    rpt        = '0;
    abort      = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_single();
    test_repeat();
    test_abort();
    test_ignored_load();
    test_reset_mid();
    test_len0();
    test_len_clamp();
    test_abort_with_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
